hazard_stall_ctrl: RTL and testbench

Pipeline hazard and stall controller for the 5-stage MIPS core. It sits in ID, directly upstream of the 1-bit control-select muxes between ID and ID/EX. It drives their select (`ctrl_sel`) to inject bubbles, and drives PC/IF-ID write enables, the IF/ID flush and the EX/MEM hold. It handles load-use stalls, taken-branch flushes with a configurable penalty, and multi-cycle data-memory waits, and keeps a stall-cycle counter.

---
 rtl/hazard_pkg.sv | 39 +++
 rtl/hazard_stall_ctrl_if.sv | 30 +++
 rtl/load_use_detect.sv | 16 +
 rtl/hazard_stall_ctrl.sv | 106 ++++++++++
 tb/tb_hazard_stall_ctrl.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings for the ID-stage hazard/stall controller.
package hazard_pkg;

  localparam logic [1:0] ST_IDLE       = 2'b00;
  localparam logic [1:0] ST_LOAD_STALL = 2'b01;
  localparam logic [1:0] ST_FLUSH      = 2'b10;
  localparam logic [1:0] ST_MEM_WAIT   = 2'b11;

  localparam int REG_ZERO   = 0;
  localparam int BR_PEN_MIN = 1;
  localparam int BR_PEN_MAX = 3;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic ctrl_sel;
    logic exmem_hold;
  } ctl_t;

  localparam ctl_t CTL_DEFAULT = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0,
                                   ctrl_sel: 1'b0, exmem_hold: 1'b0};
  localparam ctl_t CTL_HOLD    = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                   ctrl_sel: 1'b0, exmem_hold: 1'b1};
  localparam ctl_t CTL_FLUSH   = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1,
                                   ctrl_sel: 1'b1, exmem_hold: 1'b0};
  localparam ctl_t CTL_STALL   = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                   ctrl_sel: 1'b1, exmem_hold: 1'b0};
  localparam ctl_t CTL_RESET   = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b1,
                                   ctrl_sel: 1'b1, exmem_hold: 1'b0};

  // Clamp a requested branch penalty into the supported range.
  function automatic int clamp_penalty(input int pen);
    if (pen < BR_PEN_MIN) return BR_PEN_MIN;
    if (pen > BR_PEN_MAX) return BR_PEN_MAX;
    return pen;
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-facing bundle: hazard inputs from ID/EX/MEM, stall/flush controls back.
interface hazard_stall_ctrl_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             idex_mem_read;
  logic [REG_W-1:0] idex_rt;
  logic             ex_branch_taken;
  logic             mem_busy;

  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             ctrl_sel;
  logic             exmem_hold;
  logic [CNT_W-1:0] stall_count;
  logic [1:0]       state_o;

  modport master (
    output id_rs, id_rt, idex_mem_read, idex_rt, ex_branch_taken, mem_busy,
    input  pc_write, ifid_write, ifid_flush, ctrl_sel, exmem_hold, stall_count, state_o
  );

  modport slave (
    input  id_rs, id_rt, idex_mem_read, idex_rt, ex_branch_taken, mem_busy,
    output pc_write, ifid_write, ifid_flush, ctrl_sel, exmem_hold, stall_count, state_o
  );
endinterface

// File: rtl/load_use_detect.sv
// Load-use comparator: load in EX writes a register the ID instruction reads.
module load_use_detect
  import hazard_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic             idex_mem_read,
  input  logic [REG_W-1:0] idex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  output logic             lu
);
  // $zero is never a real dependency.
  assign lu = idex_mem_read && (idex_rt != REG_W'(REG_ZERO)) &&
              ((idex_rt == id_rs) || (idex_rt == id_rt));
endmodule

// File: rtl/hazard_stall_ctrl.sv
// ID-stage hazard FSM: load-use bubbles, branch flushes, data-memory waits, stall counter.
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_W      = 5,
  parameter int BR_PENALTY = 1,
  parameter int CNT_W      = 16
) (
  input logic                clk,
  input logic                rst_n,
  hazard_stall_ctrl_if.slave bus
);
  localparam int         PEN      = clamp_penalty(BR_PENALTY);
  localparam int         CNT_INIT = (PEN > 1) ? PEN - 2 : 0;
  localparam logic [1:0] CNT_LOAD = 2'(CNT_INIT);

  logic [1:0] state, state_nx;
  logic [1:0] ret, ret_nx;
  logic [1:0] cnt, cnt_nx;
  logic [1:0] eff;
  logic       lu;
  ctl_t       ctl;

  load_use_detect #(.REG_W(REG_W)) u_lu (
    .idex_mem_read (bus.idex_mem_read),
    .idex_rt       (bus.idex_rt),
    .id_rs         (bus.id_rs),
    .id_rt         (bus.id_rt),
    .lu            (lu)
  );

  always_comb begin
    ctl      = CTL_DEFAULT;
    state_nx = state;
    ret_nx   = ret;
    cnt_nx   = cnt;
    // Releasing a memory wait replays the interrupted state against live inputs.
    eff = (state == ST_MEM_WAIT) ? (bus.mem_busy ? ST_MEM_WAIT : ret) : state;
    case (eff)
      ST_IDLE, ST_LOAD_STALL: begin
        if (bus.mem_busy) begin
          ctl      = CTL_HOLD;
          ret_nx   = ST_IDLE;
          state_nx = ST_MEM_WAIT;
        end else if (bus.ex_branch_taken) begin
          ctl = CTL_FLUSH;
          if (PEN > 1) begin
            cnt_nx   = CNT_LOAD;
            state_nx = ST_FLUSH;
          end else begin
            state_nx = ST_IDLE;
          end
        end else if (lu && (eff == ST_IDLE)) begin
          ctl      = CTL_STALL;
          state_nx = ST_LOAD_STALL;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        if (bus.mem_busy) begin
          ctl      = CTL_HOLD;
          ret_nx   = ST_FLUSH;
          state_nx = ST_MEM_WAIT;
        end else begin
          ctl = CTL_FLUSH;
          if (cnt == 2'd0) begin
            state_nx = ST_IDLE;
          end else begin
            cnt_nx   = cnt - 2'd1;
            state_nx = ST_FLUSH;
          end
        end
      end
      default: ctl = CTL_HOLD;
    endcase
    if (!rst_n) ctl = CTL_RESET;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      ret   <= ST_IDLE;
      cnt   <= 2'd0;
    end else begin
      state <= state_nx;
      ret   <= ret_nx;
      cnt   <= cnt_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      bus.stall_count <= '0;
    else if (!ctl.pc_write && (bus.stall_count != {CNT_W{1'b1}}))
      bus.stall_count <= bus.stall_count + 1'b1;
  end

  assign bus.pc_write   = ctl.pc_write;
  assign bus.ifid_write = ctl.ifid_write;
  assign bus.ifid_flush = ctl.ifid_flush;
  assign bus.ctrl_sel   = ctl.ctrl_sel;
  assign bus.exmem_hold = ctl.exmem_hold;
  assign bus.state_o    = state;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: per-cycle reference model plus directed literal checks.
module tb_hazard_stall_ctrl;
  localparam int REG_W = 5;
  localparam int CNT_W = 16;
  localparam int BRP   = 3;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic ctrl_sel;
    logic exmem_hold;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   passes = 0;

  hazard_stall_ctrl_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();

  hazard_stall_ctrl #(.REG_W(REG_W), .BR_PENALTY(BRP), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: remaining branch-flush cycles, a "just stalled" mask, a memory-wait flag.
  int flush_left;
  bit waiting, shadow;
  int cnt_model;

  function automatic bit lu_ref();
    return bus.idex_mem_read && bus.idex_rt != 0 &&
           (bus.idex_rt == bus.id_rs || bus.idex_rt == bus.id_rt);
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    if (!rst_n)                                  e = 5'b00110;
    else if (bus.mem_busy)                       e = 5'b00001;
    else if (flush_left > 0 || bus.ex_branch_taken) e = 5'b11110;
    else if (lu_ref() && !shadow)                e = 5'b00010;
    else                                         e = 5'b11000;
    return e;
  endfunction

  function automatic int model_state();
    if (waiting)        return 3;
    if (flush_left > 0) return 2;
    if (shadow)         return 1;
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_left <= 0;
      waiting    <= 1'b0;
      shadow     <= 1'b0;
      cnt_model  <= 0;
    end else begin
      if (!model_out().pc_write && cnt_model < (1 << CNT_W) - 1) cnt_model <= cnt_model + 1;
      if (bus.mem_busy) begin
        waiting <= 1'b1;
        shadow  <= 1'b0;
      end else begin
        waiting <= 1'b0;
        if (flush_left > 0) begin
          flush_left <= flush_left - 1;
          shadow     <= 1'b0;
        end else if (bus.ex_branch_taken) begin
          flush_left <= BRP - 1;
          shadow     <= 1'b0;
        end else begin
          shadow <= lu_ref() && !shadow;
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    e = model_out();
    check("m_pc_write",    32'(bus.pc_write),    32'(e.pc_write));
    check("m_ifid_write",  32'(bus.ifid_write),  32'(e.ifid_write));
    check("m_ifid_flush",  32'(bus.ifid_flush),  32'(e.ifid_flush));
    check("m_ctrl_sel",    32'(bus.ctrl_sel),    32'(e.ctrl_sel));
    check("m_exmem_hold",  32'(bus.exmem_hold),  32'(e.exmem_hold));
    check("m_state",       32'(bus.state_o),     32'(model_state()));
    check("m_stall_count", 32'(bus.stall_count), 32'(cnt_model));
  end

  task automatic drive(input int rs, input int rt, input bit mr, input int xrt,
                       input bit br, input bit busy);
    bus.id_rs           = REG_W'(rs);
    bus.id_rt           = REG_W'(rt);
    bus.idex_mem_read   = mr;
    bus.idex_rt         = REG_W'(xrt);
    bus.ex_branch_taken = br;
    bus.mem_busy        = busy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #2;
    check("rst_pc_write",   32'(bus.pc_write),    32'd0);
    check("rst_ifid_flush", 32'(bus.ifid_flush),  32'd1);
    check("rst_ctrl_sel",   32'(bus.ctrl_sel),    32'd1);
    check("rst_state",      32'(bus.state_o),     32'd0);
    check("rst_count",      32'(bus.stall_count), 32'd0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Load-use on rs
    drive(8, 3, 1, 8, 0, 0);
    #2;
    check("lu_pc_write",   32'(bus.pc_write),   32'd0);
    check("lu_ifid_write", 32'(bus.ifid_write), 32'd0);
    check("lu_ctrl_sel",   32'(bus.ctrl_sel),   32'd1);
    step();
    #2;
    check("lu2_state",    32'(bus.state_o),     32'd1);
    check("lu2_pc_write", 32'(bus.pc_write),    32'd1);
    check("lu2_ctrl_sel", 32'(bus.ctrl_sel),    32'd0);
    check("lu2_count",    32'(bus.stall_count), 32'd1);
    drive(0, 0, 0, 0, 0, 0);
    step();

    // Load writing $zero never stalls
    drive(5, 0, 1, 0, 0, 0);
    #2;
    check("zero_pc_write", 32'(bus.pc_write), 32'd1);
    check("zero_ctrl_sel", 32'(bus.ctrl_sel), 32'd0);
    step();
    check("zero_state", 32'(bus.state_o),     32'd0);
    check("zero_count", 32'(bus.stall_count), 32'd1);
    drive(0, 0, 0, 0, 0, 0);
    step();

    // Taken branch: three flush cycles (IDLE, FLUSH, FLUSH)
    drive(0, 0, 0, 0, 1, 0);
    #2;
    check("br0_flush", 32'(bus.ifid_flush), 32'd1);
    check("br0_ctrl",  32'(bus.ctrl_sel),   32'd1);
    check("br0_pc",    32'(bus.pc_write),   32'd1);
    step();
    drive(0, 0, 0, 0, 0, 0);
    #2;
    check("br1_state", 32'(bus.state_o),    32'd2);
    check("br1_flush", 32'(bus.ifid_flush), 32'd1);
    step();
    check("br2_state", 32'(bus.state_o),    32'd2);
    check("br2_flush", 32'(bus.ifid_flush), 32'd1);
    step();
    check("br3_state", 32'(bus.state_o),     32'd0);
    check("br3_flush", 32'(bus.ifid_flush),  32'd0);
    check("br3_count", 32'(bus.stall_count), 32'd1);

    // Memory wait inside a flush
    drive(0, 0, 0, 0, 1, 0);
    step();
    drive(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      #2;
      check("mw_hold", 32'(bus.exmem_hold), 32'd1);
      check("mw_pc",   32'(bus.pc_write),   32'd0);
      step();
    end
    drive(0, 0, 0, 0, 0, 0);
    #2;
    check("mw_rel_state", 32'(bus.state_o),     32'd3);
    check("mw_rel_flush", 32'(bus.ifid_flush),  32'd1);
    check("mw_count",     32'(bus.stall_count), 32'd5);
    repeat (3) step();
    check("mw_end_state", 32'(bus.state_o), 32'd0);

    // All three events at once; branch still pending on release
    drive(8, 0, 1, 8, 1, 1);
    #2;
    check("sim_hold", 32'(bus.exmem_hold), 32'd1);
    check("sim_ctrl", 32'(bus.ctrl_sel),   32'd0);
    check("sim_pc",   32'(bus.pc_write),   32'd0);
    step();
    drive(8, 0, 1, 8, 1, 0);
    #2;
    check("sim_rel_state", 32'(bus.state_o),    32'd3);
    check("sim_rel_flush", 32'(bus.ifid_flush), 32'd1);
    check("sim_rel_pc",    32'(bus.pc_write),   32'd1);
    step();
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) step();
    check("sim_end_state", 32'(bus.state_o),     32'd0);
    check("sim_count",     32'(bus.stall_count), 32'd6);

    // Asynchronous reset in the middle of a flush
    drive(0, 0, 0, 0, 1, 0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    #2;
    check("ar_pre_state", 32'(bus.state_o), 32'd2);
    #1 rst_n = 1'b0;
    #1;
    check("ar_pc",    32'(bus.pc_write),    32'd0);
    check("ar_flush", 32'(bus.ifid_flush),  32'd1);
    check("ar_ctrl",  32'(bus.ctrl_sel),    32'd1);
    check("ar_hold",  32'(bus.exmem_hold),  32'd0);
    check("ar_state", 32'(bus.state_o),     32'd0);
    check("ar_count", 32'(bus.stall_count), 32'd0);
    #1 rst_n = 1'b1;
    step();
    check("ar_post_pc",    32'(bus.pc_write),    32'd1);
    check("ar_post_flush", 32'(bus.ifid_flush),  32'd0);
    check("ar_post_state", 32'(bus.state_o),     32'd0);
    check("ar_post_count", 32'(bus.stall_count), 32'd0);
    step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
